// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default widths, used by the
// shift engine and the SPI register block.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_DIV_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  // Width needed to hold a toggle count running from 0 up to 2*data_w.
  function automatic int toggle_cnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter and SCLK edge generator. While run is high, it emits one
// strobe every div+1 cycles, alternating leading/trailing, and counts them.
// While run is low, all counters stay at zero, so a new frame always starts
// from a clean count.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = SPI_DIV_W,
  parameter int CNT_W  = toggle_cnt_w(DATA_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             lead,
  output logic             trail,
  output logic [CNT_W-1:0] toggle_count
);

  logic [DIV_W-1:0] half_cnt;
  logic             tick;

  // The counter wraps at div, so it never exceeds div even when div is all ones.
  assign tick  = run && (half_cnt == div);
  assign lead  = tick && !toggle_count[0];
  assign trail = tick &&  toggle_count[0];

  // Advance the half-period counter and the toggle count while a frame runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt     <= '0;
      toggle_count <= '0;
    end else if (!run) begin
      half_cnt     <= '0;
      toggle_count <= '0;
    end else if (tick) begin
      half_cnt     <= '0;
      toggle_count <= toggle_count + CNT_W'(1);
    end else begin
      half_cnt     <= half_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: accepts one frame at a time, serialises it on MOSI,
// assembles MISO into rx_data, and supports all four SPI modes, both bit
// orders, a programmable SCLK divider and a synchronous abort.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = SPI_DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              abort,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int              CNT_W    = toggle_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_TOG = CNT_W'(2 * DATA_W - 1);

  spi_state_e        state;
  spi_state_e        state_next;

  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_shifted;
  logic [DIV_W-1:0]  div_l;
  logic              cpol_l;
  logic              cpha_l;
  logic              lsb_l;

  logic              lead;
  logic              trail;
  logic [CNT_W-1:0]  toggle_count;

  logic              run;
  logic              final_edge;
  logic              finish;
  logic              sample;
  logic              advance;

  assign run        = (state == SHIFT);
  assign final_edge = trail && (toggle_count == LAST_TOG);
  assign finish     = final_edge && !abort;

  // toggle_count holds k-1 for the strobe currently firing.
  // With cpha=1 the first bit stays put through the first leading edge; with
  // cpha=0 there is no advance on the closing trailing edge.
  assign sample  = cpha_l ? trail : lead;
  assign advance = cpha_l ? (lead && (toggle_count != '0)) : (trail && !final_edge);

  // Received bits are packed in the same order they were transmitted.
  assign rx_shifted = lsb_l ? {spi_miso, rx_sr[DATA_W-1:1]}
                            : {rx_sr[DATA_W-2:0], spi_miso};

  spi_clk_gen #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W),
    .CNT_W  (CNT_W)
  ) u_clk_gen (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .div          (div_l),
    .lead         (lead),
    .trail        (trail),
    .toggle_count (toggle_count)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: abort wins over frame completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tx_valid) state_next = SHIFT;
      SHIFT:   if (abort || finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state == SHIFT);
  end

  // Datapath: latch the frame and config on accept, then shift on the strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      div_l    <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      lsb_l    <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          spi_sclk <= cpol;
          if (tx_valid) begin
            div_l    <= clk_div;
            cpol_l   <= cpol;
            cpha_l   <= cpha;
            lsb_l    <= lsb_first;
            rx_sr    <= '0;
            spi_mosi <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
            tx_sr    <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
          end
        end
        SHIFT: begin
          if (abort) begin
            spi_sclk <= cpol_l;
          end else begin
            if (lead || trail) spi_sclk <= ~spi_sclk;
            if (sample) rx_sr <= rx_shifted;
            if (advance) begin
              spi_mosi <= lsb_l ? tx_sr[0] : tx_sr[DATA_W-1];
              tx_sr    <= lsb_l ? (tx_sr >> 1) : (tx_sr << 1);
            end
            if (final_edge) begin
              rx_data  <= sample ? rx_shifted : rx_sr;
              rx_valid <= 1'b1;
            end
          end
        end
        default: spi_sclk <= cpol_l;
      endcase
    end
  end

endmodule
